// File: rtl/arp_ctrl_pkg.sv
// Shared ARP controller definitions: frame type codes, broadcast address,
// FSM state encoding and counter sizing helper.
package arp_ctrl_pkg;

  localparam logic        ARP_REQ   = 1'b0;
  localparam logic        ARP_REPLY = 1'b1;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SEND       = 2'd1,
    ST_WAIT_TX    = 2'd2,
    ST_WAIT_REPLY = 2'd3
  } arp_state_e;

  // Bits needed to hold values 0..max_val without wrapping.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arp_cache.sv
// Single-entry ARP cache: overwritten by every received ARP frame,
// combinational lookup against the IP being resolved.
module arp_cache
  import arp_ctrl_pkg::*;
(
  input  logic        gmii_clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [47:0] wr_mac,
  input  logic [31:0] wr_ip,
  input  logic [31:0] lookup_ip,
  output logic        hit,
  output logic        cache_valid,
  output logic [47:0] cache_mac,
  output logic [31:0] cache_ip
);

  always_ff @(posedge gmii_clk) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_mac   <= '0;
      cache_ip    <= '0;
    end else if (wr_en) begin
      cache_valid <= 1'b1;
      cache_mac   <= wr_mac;
      cache_ip    <= wr_ip;
    end
  end

  assign hit = cache_valid && (cache_ip == lookup_ip);

endmodule

// File: rtl/arp_ctrl.sv
// ARP control FSM: answers incoming requests, resolves one IP at a time with
// timed retries, and keeps a single learned MAC/IP entry.
module arp_ctrl
  import arp_ctrl_pkg::*;
#(
  parameter int REQ_TIMEOUT = 125_000_000,
  parameter int MAX_TRY     = 3
) (
  input  logic        gmii_clk,
  input  logic        rst,
  input  logic        arp_rx_done,
  input  logic        arp_rx_type,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic        gmii_tx_done,
  input  logic        resolve_req,
  input  logic [31:0] resolve_ip,
  output logic        arp_tx_en,
  output logic        arp_tx_type,
  output logic [47:0] des_mac,
  output logic [31:0] des_ip,
  output logic        resolve_busy,
  output logic        resolve_done,
  output logic        resolve_fail,
  output logic        cache_valid,
  output logic [47:0] cache_mac,
  output logic [31:0] cache_ip
);

  localparam int TMO_W = cnt_width(REQ_TIMEOUT);
  localparam int TRY_W = cnt_width(MAX_TRY);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(REQ_TIMEOUT - 1);
  localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRY);

  arp_state_e       state_q, state_d;
  logic             reply_pend_q;
  logic             req_pend_q;
  logic [47:0]      rq_mac_q;
  logic [31:0]      rq_ip_q;
  logic [31:0]      target_ip_q;
  logic             busy_q;
  logic [TRY_W-1:0] try_q;
  logic [TMO_W-1:0] tmo_q;
  logic             tx_type_q;
  logic [47:0]      des_mac_q;
  logic [31:0]      des_ip_q;
  logic             done_q;
  logic             fail_q;

  logic             cache_hit;
  logic             rx_request;
  logic             reply_match;
  logic             accept;
  logic             hit_done;
  logic             send_reply;
  logic             send_req;
  logic             retry;
  logic             fail;
  logic             tmo_inc;

  arp_cache u_cache (
    .gmii_clk    (gmii_clk),
    .rst         (rst),
    .wr_en       (arp_rx_done),
    .wr_mac      (src_mac),
    .wr_ip       (src_ip),
    .lookup_ip   (resolve_ip),
    .hit         (cache_hit),
    .cache_valid (cache_valid),
    .cache_mac   (cache_mac),
    .cache_ip    (cache_ip)
  );

  assign rx_request  = arp_rx_done && (arp_rx_type == ARP_REQ);
  assign reply_match = arp_rx_done && (arp_rx_type == ARP_REPLY) && busy_q &&
                       (src_ip == target_ip_q);

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    hit_done   = 1'b0;
    send_reply = 1'b0;
    send_req   = 1'b0;
    retry      = 1'b0;
    fail       = 1'b0;
    tmo_inc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (resolve_req && !busy_q) begin
          if (cache_hit) hit_done = 1'b1;
          else           accept   = 1'b1;
        end
        // A pending reply goes first; an accepted request waits in req_pend.
        if (reply_pend_q) begin
          send_reply = 1'b1;
          state_d    = ST_SEND;
        end else if (accept) begin
          send_req = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (gmii_tx_done)
          state_d = (busy_q && !reply_match) ? ST_WAIT_REPLY : ST_IDLE;
      end
      ST_WAIT_REPLY: begin
        if (!busy_q || reply_match) begin
          state_d = ST_IDLE;
        end else if (reply_pend_q) begin
          // The dispatch cycle still counts; at the last count the timer
          // holds so the retry fires as soon as the detour returns.
          send_reply = 1'b1;
          state_d    = ST_SEND;
          tmo_inc    = (tmo_q != TMO_LAST);
        end else if (req_pend_q) begin
          send_req = 1'b1;
          state_d  = ST_SEND;
        end else if (tmo_q == TMO_LAST) begin
          if (try_q < TRY_MAX) begin
            retry    = 1'b1;
            send_req = 1'b1;
            state_d  = ST_SEND;
          end else begin
            fail    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          tmo_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge gmii_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      reply_pend_q <= 1'b0;
      req_pend_q   <= 1'b0;
      target_ip_q  <= '0;
      busy_q       <= 1'b0;
      try_q        <= '0;
      tmo_q        <= '0;
      tx_type_q    <= ARP_REQ;
      des_mac_q    <= '0;
      des_ip_q     <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= hit_done || reply_match;
      fail_q  <= fail;

      if (rx_request)
        reply_pend_q <= 1'b1;
      else if ((state_q == ST_SEND) && (tx_type_q == ARP_REPLY))
        reply_pend_q <= 1'b0;

      if (reply_match || fail)
        req_pend_q <= 1'b0;
      else if (accept && reply_pend_q)
        req_pend_q <= 1'b1;
      else if (send_req)
        req_pend_q <= 1'b0;

      if (accept)
        busy_q <= 1'b1;
      else if (reply_match || fail)
        busy_q <= 1'b0;

      if (accept)
        target_ip_q <= resolve_ip;

      if (accept)
        try_q <= TRY_W'(1);
      else if (retry)
        try_q <= try_q + TRY_W'(1);

      if (send_req)
        tmo_q <= '0;
      else if (tmo_inc)
        tmo_q <= tmo_q + TMO_W'(1);

      if (send_reply) begin
        tx_type_q <= ARP_REPLY;
        des_mac_q <= rq_mac_q;
        des_ip_q  <= rq_ip_q;
      end else if (send_req) begin
        tx_type_q <= ARP_REQ;
        des_mac_q <= BCAST_MAC;
        des_ip_q  <= accept ? resolve_ip : target_ip_q;
      end
    end
  end

  // Requester latch is pure data; only the reply_pend flag qualifies it.
  always_ff @(posedge gmii_clk) begin
    if (rx_request) begin
      rq_mac_q <= src_mac;
      rq_ip_q  <= src_ip;
    end
  end

  assign arp_tx_en    = (state_q == ST_SEND);
  assign arp_tx_type  = tx_type_q;
  assign des_mac      = des_mac_q;
  assign des_ip       = des_ip_q;
  assign resolve_busy = busy_q;
  assign resolve_done = done_q;
  assign resolve_fail = fail_q;

endmodule

// File: tb/tb_arp_ctrl.sv
// Directed scenarios with randomized addresses and MAC latency; expected
// cycle times are derived from the ARP controller's behavioural rules.
`timescale 1ns/1ps
module tb_arp_ctrl;

  localparam int TMO   = 100;
  localparam int TRIES = 3;

  logic        gmii_clk = 1'b0;
  logic        rst;
  logic        arp_rx_done;
  logic        arp_rx_type;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic        gmii_tx_done;
  logic        resolve_req;
  logic [31:0] resolve_ip;
  logic        arp_tx_en;
  logic        arp_tx_type;
  logic [47:0] des_mac;
  logic [31:0] des_ip;
  logic        resolve_busy;
  logic        resolve_done;
  logic        resolve_fail;
  logic        cache_valid;
  logic [47:0] cache_mac;
  logic [31:0] cache_ip;

  arp_ctrl #(.REQ_TIMEOUT(TMO), .MAX_TRY(TRIES)) dut (
    .gmii_clk     (gmii_clk),
    .rst          (rst),
    .arp_rx_done  (arp_rx_done),
    .arp_rx_type  (arp_rx_type),
    .src_mac      (src_mac),
    .src_ip       (src_ip),
    .gmii_tx_done (gmii_tx_done),
    .resolve_req  (resolve_req),
    .resolve_ip   (resolve_ip),
    .arp_tx_en    (arp_tx_en),
    .arp_tx_type  (arp_tx_type),
    .des_mac      (des_mac),
    .des_ip       (des_ip),
    .resolve_busy (resolve_busy),
    .resolve_done (resolve_done),
    .resolve_fail (resolve_fail),
    .cache_valid  (cache_valid),
    .cache_mac    (cache_mac),
    .cache_ip     (cache_ip)
  );

  always #4 gmii_clk = ~gmii_clk;

  int cyc = 0;
  always @(posedge gmii_clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic        typ;
    logic [47:0] mac;
    logic [31:0] ip;
  } tx_ev_t;

  tx_ev_t tx_q[$];
  int     done_q[$];
  int     rdone_q[$];
  int     rfail_q[$];
  int     stab_err = 0;
  int     tests = 0;
  int     fails = 0;
  tx_ev_t mon_e;

  // Event recorder: transmissions and result pulses, tagged with cycle number.
  always @(negedge gmii_clk) begin
    if (arp_tx_en === 1'b1) begin
      mon_e.c   = cyc;
      mon_e.typ = arp_tx_type;
      mon_e.mac = des_mac;
      mon_e.ip  = des_ip;
      tx_q.push_back(mon_e);
    end
    if (resolve_done === 1'b1) rdone_q.push_back(cyc);
    if (resolve_fail === 1'b1) rfail_q.push_back(cyc);
  end

  // MAC model: finishes each frame after a random latency, watching that the
  // frame target stays put until the done pulse.
  initial begin : responder
    logic [47:0] m;
    logic [31:0] ip;
    logic        t;
    int          lat;
    bit          abort;
    gmii_tx_done = 1'b0;
    forever begin
      @(posedge gmii_clk); #1;
      if (arp_tx_en === 1'b1 && rst === 1'b0) begin
        m = des_mac; ip = des_ip; t = arp_tx_type;
        lat = $urandom_range(8, 3);
        abort = 0;
        for (int i = 0; i < lat && !abort; i++) begin
          @(posedge gmii_clk); #1;
          if (rst === 1'b1) abort = 1;
          else if (des_mac !== m || des_ip !== ip || arp_tx_type !== t) stab_err++;
        end
        if (!abort) begin
          gmii_tx_done = 1'b1;
          done_q.push_back(cyc);
          @(posedge gmii_clk); #1;
          gmii_tx_done = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < %0d", cyc, 120000);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge gmii_clk); #1; end
  endtask

  task automatic rx_pulse(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
    arp_rx_done = 1'b1; arp_rx_type = typ; src_mac = mac; src_ip = ip;
    tick(1);
    arp_rx_done = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] ip);
    resolve_req = 1'b1; resolve_ip = ip;
    tick(1);
    resolve_req = 1'b0;
  endtask

  task automatic wait_dones(input int n, input int budget, input string tag);
    int b = 0;
    while (done_q.size() < n && b < budget) begin tick(1); b++; end
    check({tag, "_wait"}, done_q.size() >= n, 1);
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int b = 0;
    while (tx_q.size() < n && b < budget) begin tick(1); b++; end
    check({tag, "_wait"}, tx_q.size() >= n, 1);
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic clear_q();
    tx_q.delete(); done_q.delete(); rdone_q.delete(); rfail_q.delete();
  endtask

  function automatic tx_ev_t tx_at(input int i);
    tx_ev_t e;
    e.c = -1; e.typ = 1'bx; e.mac = 'x; e.ip = 'x;
    if (i < tx_q.size()) e = tx_q[i];
    return e;
  endfunction

  function automatic int done_at(input int i);
    return (i < done_q.size()) ? done_q[i] : -1;
  endfunction

  function automatic int rdone_only();
    return (rdone_q.size() == 1) ? rdone_q[0] : -1;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_en"},  arp_tx_en,    0);
    check({tag, "_type"},   arp_tx_type,  0);
    check({tag, "_dmac"},   des_mac,      0);
    check({tag, "_dip"},    des_ip,       0);
    check({tag, "_busy"},   resolve_busy, 0);
    check({tag, "_done"},   resolve_done, 0);
    check({tag, "_fail"},   resolve_fail, 0);
    check({tag, "_cvalid"}, cache_valid,  0);
    check({tag, "_cmac"},   cache_mac,    0);
    check({tag, "_cip"},    cache_ip,     0);
  endtask

  initial begin : main
    int          k, c, s, d, exp_c, r_at;
    logic [47:0] mac, rmac, mac5;
    logic [31:0] ip, rip, ip3, ip5, ip6, last_ip;
    logic [47:0] last_mac;

    rst = 1'b1; arp_rx_done = 1'b0; arp_rx_type = 1'b0; src_mac = '0; src_ip = '0;
    resolve_req = 1'b0; resolve_ip = '0;
    tick(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    tick(2);

    // Resolve on an empty cache, reply 50 cycles after the frame went out.
    clear_q();
    k = cyc;
    resolve(32'hC0A8_0003);
    check("s2_busy", resolve_busy, 1);
    wait_dones(1, 50, "s2_tx");
    check("s2_tx_cnt", tx_q.size(), 1);
    check("s2_tx_cyc", tx_at(0).c, k + 1);
    check("s2_tx_type", tx_at(0).typ, 0);
    check("s2_tx_mac", tx_at(0).mac, 48'hFFFF_FFFF_FFFF);
    check("s2_tx_ip", tx_at(0).ip, 32'hC0A8_0003);
    c = done_at(0);
    mac = {16'h02AB, $urandom()};
    wait_cycle(c + 50);
    rx_pulse(1'b1, mac, 32'hC0A8_0003);
    tick(2);
    check("s2_done_cyc", rdone_only(), c + 51);
    check("s2_busy_clr", resolve_busy, 0);
    check("s2_cvalid", cache_valid, 1);
    check("s2_cip", cache_ip, 32'hC0A8_0003);
    check("s2_cmac", cache_mac, mac);
    check("s2_no_extra_tx", tx_q.size(), 1);
    check("s2_no_fail", rfail_q.size(), 0);

    // Incoming requests: the fixed case first, then random requesters.
    last_ip = '0; last_mac = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        mac = 48'h0011_2233_4455; ip = 32'hC0A8_0003;
      end else begin
        mac = {16'h0A00, $urandom()}; ip = {8'd10, 24'($urandom())};
      end
      clear_q();
      k = cyc;
      rx_pulse(1'b0, mac, ip);
      check("s1_cvalid", cache_valid, 1);
      check("s1_cip", cache_ip, ip);
      check("s1_cmac", cache_mac, mac);
      wait_dones(1, 40, "s1_tx");
      tick(3);
      check("s1_tx_cnt", tx_q.size(), 1);
      check("s1_tx_cyc", tx_at(0).c, k + 2);
      check("s1_tx_type", tx_at(0).typ, 1);
      check("s1_tx_mac", tx_at(0).mac, mac);
      check("s1_tx_ip", tx_at(0).ip, ip);
      check("s1_busy", resolve_busy, 0);
      check("s1_no_done", rdone_q.size(), 0);
      last_ip = ip; last_mac = mac;
    end

    // Resolve an IP that is already cached: answered without transmitting.
    clear_q();
    k = cyc;
    resolve(last_ip);
    tick(20);
    check("s4_done_cyc", rdone_only(), k + 1);
    check("s4_no_tx", tx_q.size(), 0);
    check("s4_busy", resolve_busy, 0);

    // No reply at all: MAX_TRY requests, each one timeout after the last done.
    clear_q();
    ip3 = {8'd172, 24'($urandom())};
    k = cyc;
    resolve(ip3);
    begin
      int b = 0;
      while (rfail_q.size() == 0 && b < 600) begin tick(1); b++; end
    end
    check("s3_fail_seen", rfail_q.size(), 1);
    check("s3_tx_cnt", tx_q.size(), TRIES);
    check("s3_done_cnt", done_q.size(), TRIES);
    check("s3_tx0_cyc", tx_at(0).c, k + 1);
    for (int i = 0; i < tx_q.size(); i++) begin
      check("s3_tx_type", tx_at(i).typ, 0);
      check("s3_tx_mac", tx_at(i).mac, 48'hFFFF_FFFF_FFFF);
      check("s3_tx_ip", tx_at(i).ip, ip3);
      if (i > 0) check("s3_retry_cyc", tx_at(i).c, done_at(i - 1) + TMO + 1);
    end
    check("s3_fail_cyc", (rfail_q.size() > 0) ? rfail_q[0] : -1, done_at(TRIES - 1) + TMO + 1);
    check("s3_busy", resolve_busy, 0);
    check("s3_no_done", rdone_q.size(), 0);
    tick(TMO + 20);
    check("s3_quiet_tx", tx_q.size(), TRIES);
    check("s3_single_fail", rfail_q.size(), 1);

    // Request arrives at timeout count 40: reply detour, timer resumes.
    clear_q();
    ip5  = {16'hC0A8, 8'd100, 8'($urandom())};
    mac5 = {16'h0C00, $urandom()};
    k = cyc;
    resolve(ip5);
    wait_dones(1, 50, "s5_tx0");
    c = done_at(0);
    rmac = {16'h0B00, $urandom()};
    rip  = {8'd10, 24'($urandom())};
    wait_cycle(c + 41);
    rx_pulse(1'b0, rmac, rip);
    wait_dones(2, 50, "s5_reply");
    tick(2);
    check("s5_reply_cyc", tx_at(1).c, c + 43);
    check("s5_reply_type", tx_at(1).typ, 1);
    check("s5_reply_mac", tx_at(1).mac, rmac);
    check("s5_reply_ip", tx_at(1).ip, rip);
    check("s5_busy_held", resolve_busy, 1);
    s = tx_at(1).c;
    d = done_at(1);
    exp_c = c + TMO + 1 + (d - s + 1);
    wait_tx(3, 250, "s5_retry");
    check("s5_retry_cyc", tx_at(2).c, exp_c);
    check("s5_retry_type", tx_at(2).typ, 0);
    check("s5_retry_ip", tx_at(2).ip, ip5);
    wait_dones(3, 50, "s5_retry_done");
    r_at = done_at(2) + $urandom_range(30, 5);
    wait_cycle(r_at);
    rx_pulse(1'b1, mac5, ip5);
    tick(2);
    check("s5_done_cyc", rdone_only(), r_at + 1);
    check("s5_busy_clr", resolve_busy, 0);
    check("s5_cip", cache_ip, ip5);
    check("s5_cmac", cache_mac, mac5);
    check("s5_no_fail", rfail_q.size(), 0);

    // Reset while waiting for the MAC, then resolve the previously cached IP.
    clear_q();
    ip6 = {8'd192, 8'd0, 16'($urandom())};
    resolve(ip6);
    tick(1);
    check("s6_busy_pre", resolve_busy, 1);
    rst = 1'b1;
    tick(1);
    check_outputs_zero("s6_rst");
    tick(2);
    rst = 1'b0;
    tick(2);
    clear_q();
    k = cyc;
    resolve(ip5);
    check("s6_cache_empty", cache_valid, 0);
    check("s6_busy", resolve_busy, 1);
    wait_dones(1, 50, "s6_tx");
    check("s6_tx_cnt", tx_q.size(), 1);
    check("s6_tx_cyc", tx_at(0).c, k + 1);
    check("s6_tx_type", tx_at(0).typ, 0);
    check("s6_tx_ip", tx_at(0).ip, ip5);
    check("s6_no_hit", rdone_q.size(), 0);
    r_at = cyc + 3;
    wait_cycle(r_at);
    rx_pulse(1'b1, mac5, ip5);
    tick(2);
    check("s6_done_cyc", rdone_only(), r_at + 1);
    check("s6_busy_clr", resolve_busy, 0);

    check("des_stable", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
